pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard, forwarding and stall controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). It replaces the separate load-use detector and forwarding selector with a single block. It adds multi-cycle EX-unit occupancy tracking for MUL, so the multiplier can take `MUL_LAT` cycles, and control-redirect flushing. All pipeline-register enables, bubbles and bypass selects come from this block.

## Interface
- `REG_AW`, 5: register-address width.
- `MUL_LAT`, 3: EX occupancy of a MUL in cycles, ≥1 (1 = single-cycle, no freeze).
- `CNT_W`, 16: width of the performance counters.

- `Clk` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `id_valid`, `id_uses_rs`, `id_uses_rt`, `id_is_mul` in 1 each: ID-stage instruction qualifiers.
- `id_rs`, `id_rt` in `REG_AW`: ID source registers.
- `ex_valid`, `ex_reg_write`, `ex_mem_read` in 1 each; `ex_rs`, `ex_rt`, `ex_rd` in `REG_AW`: EX-stage instruction.
- `mem_valid`, `mem_reg_write` in 1; `mem_rd` in `REG_AW`: MEM stage.
- `wb_valid`, `wb_reg_write` in 1; `wb_rd` in `REG_AW`: WB stage.
- `redirect` in 1: taken branch or jump resolved in EX this cycle.
- `pc_write`, `if_id_write` out 1: enables for the PC and the IF/ID register.
- `if_id_flush`, `id_ex_bubble`, `ex_mem_bubble` out 1: insert a NOP into the named register at the next edge.
- `fwd_a_sel`, `fwd_b_sel` out 2: EX operand select. 0 = register file, 1 = MEM result, 2 = WB result. 3 is never driven.
- `id_byp_a`, `id_byp_b` out 1: ID-stage WB→ID bypass for the same-cycle register write.
- `mul_busy` out 1: the multiplier occupies EX.
- `stall_cycles`, `flush_count` out `CNT_W`: performance counters (see Configuration).

## Operation
- Register 0 never creates a hazard or a forward. Any match against address 0 is ignored.
- **Load-use stall (`lu`)**: `id_valid & ex_valid & ex_mem_read & ex_rd≠0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd))`.
- **MUL FSM**, states IDLE and BUSY, with down-counter `mcnt` of width clog2(`MUL_LAT`).
  - IDLE→BUSY when `id_valid & id_is_mul` advances into EX (no stall, no redirect) and `MUL_LAT>1`. `mcnt` loads `MUL_LAT-1`.
  - In BUSY, `mcnt` decrements each cycle. BUSY→IDLE on the cycle `mcnt==1` is observed.
  - `mul_busy` = state is BUSY.
- **Freeze (`mul_busy`)**: `pc_write=0`, `if_id_write=0`, `ex_mem_bubble=1`, and the ID/EX register holds its contents. `id_ex_bubble=0` during the freeze because ID/EX is held, not bubbled.
- **Load-use response**: `pc_write=0`, `if_id_write=0`, `id_ex_bubble=1`.
- **Redirect response**: `if_id_flush=1`, `id_ex_bubble=1`, `pc_write=1`.
- **Priority**: Reset > mul_busy > redirect > lu. While `mul_busy` is high, `redirect` is ignored, because the instruction in EX is the MUL.
- **Forwarding, operand A** (operand B is identical using `ex_rt`):
  - `fwd_a_sel=1` if `mem_valid & mem_reg_write & mem_rd≠0 & mem_rd==ex_rs`.
  - Else 2 if `wb_valid & wb_reg_write & wb_rd≠0 & wb_rd==ex_rs`.
  - Else 0.
  - MEM has priority over WB.
- **ID bypass**: `id_byp_a = wb_valid & wb_reg_write & wb_rd≠0 & wb_rd==id_rs`; `id_byp_b` uses `id_rt` in the same way.

## Timing
- All stall, flush, bubble, forward and bypass outputs are combinational from the current-cycle inputs and FSM state, with zero latency.
- A load-use stall lasts exactly 1 cycle, because the load leaves EX at the next edge.
- A MUL holds EX for `MUL_LAT` cycles total: 1 cycle in IDLE plus `MUL_LAT-1` cycles in BUSY.
- While `Reset` is high:
  - `pc_write=0`, `if_id_write=0`, `if_id_flush=1`, `id_ex_bubble=1`, `ex_mem_bubble=1`.
  - `fwd_*_sel=0`, `id_byp_*=0`, `mul_busy=0`.
  - At the edge: FSM→IDLE, `mcnt=0`, counters=0.
- If `Reset` is asserted mid-BUSY, the FSM aborts to IDLE at that edge. The next cycle is a normal IDLE cycle.
- A MUL arriving in ID in the same cycle as `redirect` is flushed, and the FSM stays IDLE.
- A MUL in ID whose operand hits a load in EX takes `lu` first. It enters BUSY only on the cycle it actually advances.

## Configuration
- **`HAZARD_PERF_CNT_EN` defined**:
  - `stall_cycles` increments on every cycle with `lu | mul_busy`.
  - `flush_count` increments on every accepted redirect.
  - Both saturate at 2^`CNT_W`-1 and clear on `Reset`.
- **`HAZARD_PERF_CNT_EN` undefined**: both outputs are constant 0 and no counter flops are present. All other behaviour is identical.

## Test plan
- **Load-use**: `ex_mem_read=1`, `ex_rd=8`, `id_rs=8`, `id_uses_rs=1` → `pc_write=0`, `if_id_write=0`, `id_ex_bubble=1` for 1 cycle, then the stall releases.
- **Forward priority**: `ex_rs=5`, `mem_rd=5`, `wb_rd=5`, both writing → `fwd_a_sel=1`. Dropping `mem_reg_write` gives 2. Setting all `rd=0` gives 0.
- **MUL with `MUL_LAT=4`**: a MUL advances → `mul_busy=1` for exactly 3 cycles, `ex_mem_bubble=1` in each of them, and `pc_write=0` throughout.
- **Redirect vs stall**: `redirect=1` and `lu` in the same cycle → `if_id_flush=1`, `id_ex_bubble=1`, `pc_write=1`, and with the macro defined `flush_count` becomes 1. During `mul_busy`, `redirect` has no effect.
- **Reset mid-BUSY**: at BUSY cycle 2, `Reset=1` for 1 cycle → the next cycle shows `mul_busy=0` and `stall_cycles=0`.
- **Macro-off build**: the same MUL stimulus → `stall_cycles` and `flush_count` stay at 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard, forwarding, MUL-freeze and redirect control for the 5-stage pipeline
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
   parameter int REG_AW  = 5,
   parameter int MUL_LAT = 3,
   parameter int CNT_W   = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              id_valid,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              id_is_mul,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              ex_valid,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rs,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              mem_valid,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              wb_valid,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              redirect,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              if_id_flush,
   output logic              id_ex_bubble,
   output logic              ex_mem_bubble,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              id_byp_a,
   output logic              id_byp_b,
   output logic              mul_busy,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_count
);

   localparam int MCNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [MCNT_W-1:0] MCNT_LOAD = MCNT_W'(MUL_LAT - 1);
   localparam logic [MCNT_W-1:0] MCNT_ONE  = MCNT_W'(1);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [MCNT_W-1:0] r_mcnt;
   logic [MCNT_W-1:0] w_mcnt_nxt;

   logic w_busy;
   logic w_lu;
   logic w_mul_adv;
   logic w_mem_fwd_ok;
   logic w_wb_fwd_ok;

   // ex_reg_write is not needed: a load always writes its rd
   logic w_unused;
   assign w_unused = ex_reg_write;

   assign w_busy = (r_state == S_BUSY);

   assign w_lu = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                 ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

   // A MUL only starts the freeze on the cycle it really moves into EX
   assign w_mul_adv = id_valid & id_is_mul & ~w_lu & ~redirect & ~w_busy;

   assign w_mem_fwd_ok = mem_valid & mem_reg_write & (mem_rd != '0);
   assign w_wb_fwd_ok  = wb_valid & wb_reg_write & (wb_rd != '0);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_mcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_mcnt  <= w_mcnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_mcnt_nxt    = r_mcnt;
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;
      fwd_a_sel     = 2'd0;
      fwd_b_sel     = 2'd0;
      id_byp_a      = 1'b0;
      id_byp_b      = 1'b0;
      mul_busy      = 1'b0;

      case (r_state)
         S_IDLE: begin
            if ((MUL_LAT > 1) && w_mul_adv) begin
               w_state_nxt = S_BUSY;
               w_mcnt_nxt  = MCNT_LOAD;
            end
         end
         S_BUSY: begin
            if (r_mcnt == MCNT_ONE) begin
               w_state_nxt = S_IDLE;
               w_mcnt_nxt  = '0;
            end else begin
               w_mcnt_nxt = r_mcnt - MCNT_ONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_mcnt_nxt  = '0;
         end
      endcase

      if (Reset) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_bubble  = 1'b1;
         ex_mem_bubble = 1'b1;
      end else begin
         mul_busy = w_busy;
         // EX holds the MUL, so a redirect seen now cannot be from it
         if (w_busy) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            ex_mem_bubble = 1'b1;
         end else if (redirect) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
         end else if (w_lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
         end

         if (w_mem_fwd_ok && (mem_rd == ex_rs))     fwd_a_sel = 2'd1;
         else if (w_wb_fwd_ok && (wb_rd == ex_rs))  fwd_a_sel = 2'd2;
         if (w_mem_fwd_ok && (mem_rd == ex_rt))     fwd_b_sel = 2'd1;
         else if (w_wb_fwd_ok && (wb_rd == ex_rt))  fwd_b_sel = 2'd2;

         id_byp_a = w_wb_fwd_ok & (wb_rd == id_rs);
         id_byp_b = w_wb_fwd_ok & (wb_rd == id_rt);
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if ((w_lu | w_busy) && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if ((redirect & ~w_busy) && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign stall_cycles = r_stall_cnt;
   assign flush_count  = r_flush_cnt;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
// Expected counter values depend on HAZARD_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;

   localparam int AW  = 5;
   localparam int CW  = 4;
   localparam int SAT = 15;

   logic          Clk;
   logic          Reset;
   logic          id_valid, id_uses_rs, id_uses_rt, id_is_mul;
   logic [AW-1:0] id_rs, id_rt;
   logic          ex_valid, ex_reg_write, ex_mem_read;
   logic [AW-1:0] ex_rs, ex_rt, ex_rd;
   logic          mem_valid, mem_reg_write;
   logic [AW-1:0] mem_rd;
   logic          wb_valid, wb_reg_write;
   logic [AW-1:0] wb_rd;
   logic          redirect;
   logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_bubble;
   logic [1:0]    fwd_a_sel, fwd_b_sel;
   logic          id_byp_a, id_byp_b, mul_busy;
   logic [CW-1:0] stall_cycles, flush_count;

   int total = 0;
   int bad   = 0;
   int e_stall = 0;
   int e_flush = 0;

   pipe_hazard_ctrl #(.REG_AW(AW), .MUL_LAT(4), .CNT_W(CW)) dut (
      .Clk(Clk), .Reset(Reset),
      .id_valid(id_valid), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_mul(id_is_mul),
      .id_rs(id_rs), .id_rt(id_rt),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .redirect(redirect),
      .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .id_byp_a(id_byp_a), .id_byp_b(id_byp_b), .mul_busy(mul_busy),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic check_cnt(input string tag);
`ifdef HAZARD_PERF_CNT_EN
      check({tag, "_stall"}, 32'(stall_cycles), e_stall);
      check({tag, "_flush"}, 32'(flush_count), e_flush);
`else
      check({tag, "_stall"}, 32'(stall_cycles), 0);
      check({tag, "_flush"}, 32'(flush_count), 0);
`endif
   endtask

   task automatic idle();
      id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_is_mul = 0;
      id_rs = 0; id_rt = 0;
      ex_valid = 0; ex_reg_write = 0; ex_mem_read = 0;
      ex_rs = 0; ex_rt = 0; ex_rd = 0;
      mem_valid = 0; mem_reg_write = 0; mem_rd = 0;
      wb_valid = 0; wb_reg_write = 0; wb_rd = 0;
      redirect = 0;
   endtask

   task automatic set_load_use();
      id_valid = 1; id_uses_rs = 1; id_rs = 8;
      ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_rd = 8;
   endtask

   // s/f: whether this cycle should bump the stall / flush counter
   task automatic tick(input bit s, input bit f);
      if (Reset) begin
         e_stall = 0;
         e_flush = 0;
      end else begin
         if (s && e_stall != SAT) e_stall++;
         if (f && e_flush != SAT) e_flush++;
      end
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset = 1;
      idle();
      wb_valid = 1; wb_reg_write = 1; wb_rd = 3; id_rs = 3;
      mem_valid = 1; mem_reg_write = 1; mem_rd = 4; ex_rs = 4;
      tick(0, 0);
      #1;
      check("rst_pc_write", pc_write, 0);
      check("rst_if_id_write", if_id_write, 0);
      check("rst_if_id_flush", if_id_flush, 1);
      check("rst_id_ex_bubble", id_ex_bubble, 1);
      check("rst_ex_mem_bubble", ex_mem_bubble, 1);
      check("rst_mul_busy", mul_busy, 0);
      check("rst_fwd_a", fwd_a_sel, 0);
      check("rst_byp_a", id_byp_a, 0);
      tick(0, 0);

      Reset = 0;
      idle();
      #1;
      check("idle_pc_write", pc_write, 1);
      check("idle_if_id_write", if_id_write, 1);
      check("idle_flush", if_id_flush, 0);
      check("idle_bubble", id_ex_bubble, 0);
      check("idle_ex_mem_bubble", ex_mem_bubble, 0);
      check_cnt("idle_cnt");
      tick(0, 0);

      set_load_use();
      #1;
      check("lu_pc_write", pc_write, 0);
      check("lu_if_id_write", if_id_write, 0);
      check("lu_bubble", id_ex_bubble, 1);
      check("lu_ex_mem_bubble", ex_mem_bubble, 0);
      tick(1, 0);
      ex_mem_read = 0;
      #1;
      check("lu_release_pc", pc_write, 1);
      check("lu_release_bubble", id_ex_bubble, 0);
      check_cnt("lu_cnt");

      ex_mem_read = 1; ex_rd = 0; id_rs = 0;
      #1;
      check("lu_r0_pc", pc_write, 1);
      ex_rd = 9; id_rt = 9; id_uses_rs = 0; id_uses_rt = 0;
      #1;
      check("lu_rt_unused_pc", pc_write, 1);
      id_uses_rt = 1;
      #1;
      check("lu_rt_pc", pc_write, 0);
      idle();

      ex_rs = 5; ex_rt = 5;
      mem_valid = 1; mem_reg_write = 1; mem_rd = 5;
      wb_valid = 1; wb_reg_write = 1; wb_rd = 5;
      id_rs = 5; id_rt = 6;
      #1;
      check("fwd_a_mem", fwd_a_sel, 1);
      check("fwd_b_mem", fwd_b_sel, 1);
      check("byp_a_hit", id_byp_a, 1);
      check("byp_b_miss", id_byp_b, 0);
      mem_reg_write = 0;
      #1;
      check("fwd_a_wb", fwd_a_sel, 2);
      check("fwd_b_wb", fwd_b_sel, 2);
      ex_rt = 7;
      #1;
      check("fwd_b_none", fwd_b_sel, 0);
      mem_reg_write = 1; mem_rd = 0; wb_rd = 0; ex_rs = 0; id_rs = 0;
      #1;
      check("fwd_a_r0", fwd_a_sel, 0);
      check("byp_a_r0", id_byp_a, 0);
      idle();

      set_load_use();
      redirect = 1;
      #1;
      check("rdl_flush", if_id_flush, 1);
      check("rdl_bubble", id_ex_bubble, 1);
      check("rdl_pc_write", pc_write, 1);
      tick(1, 1);
      idle();
      #1;
      check_cnt("rdl_cnt");

      id_valid = 1; id_is_mul = 1; redirect = 1;
      tick(0, 1);
      idle();
      #1;
      check("mul_flushed_busy", mul_busy, 0);

      id_valid = 1; id_is_mul = 1;
      #1;
      check("mul_idle_busy", mul_busy, 0);
      tick(0, 0);
      idle();
      for (int i = 0; i < 3; i++) begin
         if (i == 1) redirect = 1;
         #1;
         check($sformatf("mul_busy_%0d", i), mul_busy, 1);
         check($sformatf("mul_exmem_%0d", i), ex_mem_bubble, 1);
         check($sformatf("mul_pc_%0d", i), pc_write, 0);
         check($sformatf("mul_idex_%0d", i), id_ex_bubble, 0);
         check($sformatf("mul_flush_%0d", i), if_id_flush, 0);
         tick(1, 0);
         redirect = 0;
      end
      #1;
      check("mul_done_busy", mul_busy, 0);
      check("mul_done_pc", pc_write, 1);
      check_cnt("mul_cnt");

      set_load_use();
      id_is_mul = 1;
      #1;
      check("mullu_pc", pc_write, 0);
      tick(1, 0);
      idle();
      #1;
      check("mullu_busy", mul_busy, 0);
      tick(0, 0);

      id_valid = 1; id_is_mul = 1;
      tick(0, 0);
      idle();
      tick(1, 0);
      Reset = 1;
      #1;
      check("rstbusy_busy", mul_busy, 0);
      check("rstbusy_exmem", ex_mem_bubble, 1);
      tick(0, 0);
      Reset = 0;
      #1;
      check("after_rst_busy", mul_busy, 0);
      check("after_rst_pc", pc_write, 1);
      check_cnt("after_rst_cnt");
      tick(0, 0);
      #1;
      check("after_rst_busy2", mul_busy, 0);

      set_load_use();
      redirect = 1;
      for (int i = 0; i < 20; i++) tick(1, 1);
      idle();
      #1;
      check_cnt("sat_cnt");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
